// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle multiply/divide unit sequencer with HI/LO result registers.
//   A start in IDLE latches the operation and operands, then the unit stays
//   BUSY for N cycles (5 for mult/multu, 10 for div/divu) and writes HI/LO at
//   the last busy edge. mthi/mtlo write HI/LO directly while idle.
//
//   Optional feature: define MDU_DIV_EN to include divide support. Without it,
//   a start with op=div/divu is a no-op and no divider is built.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   issue the operation selected by op
//   op[1:0]  in   00 mult, 01 multu, 10 div, 11 divu
//   rs_data  in   operand A (multiplicand / dividend)
//   rt_data  in   operand B (multiplier / divisor)
//   mthi     in   write wdata to HI (idle only)
//   mtlo     in   write wdata to LO (idle only)
//   wdata    in   data for mthi/mtlo
//   md_use   in   current instruction uses the unit
//   read_hi  in   rdata select: 1 = HI, 0 = LO
//   busy     out  operation in flight
//   stall    out  busy & md_use
//   hi, lo   out  result registers
//   rdata    out  read_hi ? hi : lo
// -----------------------------------------------------------------------------
module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        md_use,
  input  logic        read_hi,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        op_ok;
  logic        accept;
  logic        done;

  // Only operations actually built into this configuration may start.
`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept = (state == IDLE) && start && op_ok;
  assign done   = (state == BUSY) && (cnt == 4'd0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = op[1] ? 4'd9 : 4'd4;  // N-1 so busy lasts N cycles
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= 2'b00;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= rs_data;
      b_q  <= rt_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath (from latched operands; used only at the finishing edge)
  // ---------------------------------------------------------------------------
  logic        sgn;
  logic [63:0] mul_a, mul_b, product;

  assign sgn = ~op_q[0];

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // the correct signed or unsigned result.
  assign mul_a   = {{32{sgn & a_q[31]}}, a_q};
  assign mul_b   = {{32{sgn & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

`ifdef MDU_DIV_EN
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend.
  assign a_neg = sgn & a_q[31];
  assign b_neg = sgn & b_q[31];
  assign a_mag = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag = b_neg ? (32'd0 - b_q) : b_q;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;
`endif

  // ---------------------------------------------------------------------------
  // HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (!op_q[1]) begin
        hi <= product[63:32];
        lo <= product[31:0];
      end
`ifdef MDU_DIV_EN
      else if (b_q != 32'd0) begin  // divide by zero leaves HI/LO untouched
        hi <= rem;
        lo <= quot;
      end
`endif
    end else if ((state == IDLE) && !start) begin
      // start wins over mthi/mtlo issued in the same cycle
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

  assign busy  = (state == BUSY);
  assign stall = busy & md_use;
  assign rdata = read_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
//   Directed self-checking bench for mdu_sequencer. Divide expectations follow
//   the MDU_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        md_use, read_hi;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int errors = 0;

  mdu_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .md_use  (md_use),
    .read_hi (read_hi),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and count the busy cycles that follow (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      n++;
      step();
    end
  endtask

  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; mtlo = 1'b0; wdata = h;
    step();
    mthi = 1'b0; mtlo = 1'b1; wdata = l;
    step();
    mtlo = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_mthi_mtlo();
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5A5A5;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mthi_both: got %h expected a5a5a5a5", hi); end
    checks++;
    if (lo !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_both: got %h expected a5a5a5a5", lo); end
    mthi = 1'b1; wdata = 32'h11111111;
    step();
    mthi = 1'b0;
    read_hi = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h11111111) begin errors++; $display("FAIL rdata_hi: got %h expected 11111111", rdata); end
    read_hi = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rdata_lo: got %h expected a5a5a5a5", rdata); end
  endtask

  task automatic test_mult();
    int n;
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin
      errors++; $display("FAIL mult_neg1x2: got %h_%h expected ffffffff_fffffffe", hi, lo);
    end
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin
      errors++; $display("FAIL multu_ffffffffx2: got %h_%h expected 00000001_fffffffe", hi, lo);
    end
    run_op(2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, n);
    checks++;
    if ({hi, lo} !== 64'h00000000_0000000F) begin
      errors++; $display("FAIL mult_neg3xneg5: got %h_%h expected 00000000_0000000f", hi, lo);
    end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      errors++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    // start and mthi in the same idle cycle: start wins, mthi is dropped.
    start = 1'b1; op = 2'b00; rs_data = 32'd2; rt_data = 32'd3;
    mthi = 1'b1; wdata = 32'h0000FFFF;
    step();
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL start_over_mthi: got %h expected fffffffe", hi); end
    n = 0;
    while (busy && n < 30) begin n++; step(); end
    checks++;
    if ({hi, lo} !== 64'h00000000_00000006) begin
      errors++; $display("FAIL mult_2x3: got %h_%h expected 00000000_00000006", hi, lo);
    end
  endtask

  task automatic test_busy_ignore();
    int n, stall_cnt;
    load_hilo(32'hDEADBEEF, 32'h0BADF00D);
    md_use = 1'b1;
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd4;
    step();
    n = 0;
    stall_cnt = 0;
    while (busy && n < 30) begin
      n++;
      if (stall) stall_cnt++;
      if (n == 2) begin
        start = 1'b1; rs_data = 32'd99; rt_data = 32'd99;
        mthi = 1'b1; wdata = 32'h00001234;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      step();
      if (n == 2) begin
        checks++;
        if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL busy_mthi_ignored: got %h expected deadbeef", hi); end
      end
    end
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL busy_start_ignored_cycles: got %0d expected 5", n); end
    checks++;
    if (stall_cnt != 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stall_cnt); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_after_busy: got %b expected 0", stall); end
    checks++;
    if ({hi, lo} !== 64'h00000000_0000000C) begin
      errors++; $display("FAIL mult_3x4: got %h_%h expected 00000000_0000000c", hi, lo);
    end
    // Back-to-back: issue immediately in the first idle cycle.
    start = 1'b1; rs_data = 32'd6; rt_data = 32'd7;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL back_to_back_accept: got %b expected 1", busy); end
    n = 0;
    while (busy && n < 30) begin n++; step(); end
    checks++;
    if (lo !== 32'd42) begin errors++; $display("FAIL back_to_back_result: got %h expected 0000002a", lo); end
    md_use = 1'b0;
  endtask

  task automatic test_reset_busy();
    load_hilo(32'h55, 32'h55);
    start = 1'b1; op = 2'b00; rs_data = 32'd7; rt_data = 32'd9;
    step();               // accepted; busy cycle 1
    start = 1'b0;
    step();               // busy cycle 2
    reset = 1'b1;         // asserted in busy cycle 3
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: got %b expected 0", busy); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_abort_hilo: got %h_%h expected 0_0", hi, lo); end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_late_write: got %h_%h busy %b expected 0_0 busy 0", hi, lo, busy);
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    int n;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL div_neg7_2: got %h_%h expected ffffffff_fffffffd", hi, lo);
    end
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, n);
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL div_7_neg2: got %h_%h expected 00000001_fffffffd", hi, lo);
    end
    run_op(2'b11, 32'd100, 32'd7, n);
    checks++;
    if ({hi, lo} !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL divu_100_7: got %h_%h expected 00000002_0000000e", hi, lo);
    end
    load_hilo(32'h00001111, 32'h00002222);
    run_op(2'b11, 32'd7, 32'd0, n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL divu_zero_cycles: got %0d expected 10", n); end
    checks++;
    if ({hi, lo} !== 64'h00001111_00002222) begin
      errors++; $display("FAIL divu_zero_hilo: got %h_%h expected 00001111_00002222", hi, lo);
    end
  endtask
`else
  task automatic test_div_disabled();
    load_hilo(32'hCAFE0001, 32'hCAFE0002);
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; op = (k == 0) ? 2'b10 : 2'b11; rs_data = 32'd7; rt_data = 32'd2;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL div_disabled_busy op%0d: got %b expected 0", k, busy); end
      for (int i = 0; i < 11; i++) step();
      checks++;
      if ({hi, lo} !== 64'hCAFE0001_CAFE0002 || busy !== 1'b0) begin
        errors++; $display("FAIL div_disabled_hilo op%0d: got %h_%h busy %b expected cafe0001_cafe0002 busy 0", k, hi, lo, busy);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; md_use = 1'b0; read_hi = 1'b0;
    #1;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_busy_ignore();
    test_reset_busy();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
